// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Brief    : Single-clock FIFO, power-of-two depth, registered or FWFT reads.
// Revision : 1.0
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [DATA_W-1:0] datain,
    input  logic              re,
    input  logic              err_clr,
    output logic [DATA_W-1:0] dataout,
    output logic              dvalid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int             DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_AF    = (ADDR_W+1)'(AF_LVL);
    localparam logic [ADDR_W:0] C_AE    = (ADDR_W+1)'(AE_LVL);

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rd_acc, wr_acc;

    // Status flags decode straight from the count register.
    assign full         = (count_q == C_DEPTH);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= C_AF);
    assign almost_empty = (count_q <= C_AE);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        rd_acc      = re && !empty;
        // A read in the same cycle frees a slot, so a full FIFO still accepts.
        wr_acc      = we && (!full || rd_acc);
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + 1'b1;
        end
        count_d = count_q + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_acc};
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (we && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (re && !rd_acc) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset; occupancy guards against stale reads.
    always_ff @(posedge clk) begin
        if (reset && wr_acc) begin
            mem_q[wptr_q] <= datain;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dataout = empty ? '0 : mem_q[rptr_q];
            assign dvalid  = !empty;
        end else begin : g_reg_read
            logic [DATA_W-1:0] dataout_q, dataout_d;
            logic              dvalid_q, dvalid_d;

            always_comb begin
                dataout_d = dataout_q;
                dvalid_d  = rd_acc;
                if (rd_acc) begin
                    dataout_d = mem_q[rptr_q];
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    dataout_q <= '0;
                    dvalid_q  <= 1'b0;
                end else begin
                    dataout_q <= dataout_d;
                    dvalid_q  <= dvalid_d;
                end
            end

            assign dataout = dataout_q;
            assign dvalid  = dvalid_q;
        end
    endgenerate

endmodule
`default_nettype wire
